// File: rtl/block_check_seq.sv
// block_check_seq: buffers a text fragment and streams it through an external begin/end checker
module block_check_seq #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clear,
  input  logic          start,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          chk_reset,
  output logic [7:0]    chk_in,
  input  logic          chk_result
);
  typedef enum logic [2:0] {IDLE, CLR, FEED, SETTLE, DONE} state_t;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic push;
  assign push = state == IDLE && wr_en && !clear && count != FULL_CNT;
  assign full = count == FULL_CNT || state != IDLE;
  assign busy = state == CLR || state == FEED || state == SETTLE;
  assign chk_reset = reset || state == CLR;
  // byte storage, written only on accepted host writes
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  // sequencer: host buffering in IDLE, then clear / feed / settle / report
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      pass <= 1'b0;
      done <= 1'b0;
      chk_in <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            ovf <= 1'b0;
          end else begin
            if (push) begin
              wr_ptr <= wr_ptr + 1'b1;
              count <= count + 1'b1;
            end else if (wr_en) ovf <= 1'b1;
            if (start) begin
              state <= CLR;
              chk_in <= 8'h00;
            end
          end
        end
        CLR: begin
          ovf <= 1'b0;
          state <= count != '0 ? FEED : SETTLE;
          chk_in <= count != '0 ? mem[rd_ptr] : 8'h00;
        end
        FEED: begin
          rd_ptr <= rd_ptr + 1'b1;
          count <= count - 1'b1;
          state <= count == 1 ? SETTLE : FEED;
          chk_in <= count == 1 ? 8'h00 : mem[rd_ptr + 1'b1];
        end
        SETTLE: begin
          pass <= chk_result;
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/block_check_seq.md
Name: block_check_seq

Overview:
- Sequencer that sits in front of the word-level begin/end block checker (ports clk, reset, in[7:0], result).
- Buffers an ASCII text fragment written by a host into an internal byte FIFO.
- On start, clears the checker, streams the buffered bytes into it at one byte per cycle, then samples its verdict into a pass flag and pulses done.
- Owns the checker's reset and input byte exclusively; the checker itself is instantiated outside this block.

Parameters:
DEPTH, 16, FIFO capacity in bytes (power of two, >= 2)
AW, 4, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  host byte write strobe
wr_data  input  8  ASCII byte to buffer
clear  input  1  empty FIFO and clear ovf (honoured in IDLE only)
start  input  1  begin a check run (honoured in IDLE only)
full  output  1  FIFO full, or block busy
count  output  AW+1  bytes currently buffered, 0..DEPTH
ovf  output  1  sticky: a write was dropped
busy  output  1  run in progress (states CLR, FEED, SETTLE)
done  output  1  one-cycle pulse, pass valid
pass  output  1  checker verdict of last run
chk_reset  output  1  drives checker reset
chk_in  output  8  drives checker in
chk_result  input  1  checker result

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: state=IDLE; FIFO empty; count=0; ovf=0; pass=0; done=0; chk_in=8'h00.
- chk_reset = reset OR (state==CLR), combinational; all other outputs registered.
- FSM states: IDLE, CLR, FEED, SETTLE, DONE.
- IDLE:
  - wr_en with count<DEPTH pushes wr_data and count increments.
  - wr_en with count==DEPTH drops the byte and sets ovf.
  - clear empties the FIFO and clears ovf; clear beats wr_en in the same cycle.
  - start -> CLR. A write in the same cycle as start is accepted and included in the run.
  - clear and start in the same cycle: clear wins, start ignored.
- CLR (1 cycle): chk_reset=1, chk_in=0, ovf cleared. Next: FEED if count>0, else SETTLE.
- FEED:
  - Each cycle chk_in = FIFO head (registered); the head pops at the edge ending the cycle.
  - After the last byte is presented -> SETTLE.
  - Bytes are presented in write order, exactly once each, no gaps.
- SETTLE (1 cycle): chk_in=0. At the ending edge, pass <= chk_result. -> DONE.
- DONE (1 cycle): done=1, busy=0, FIFO empty. -> IDLE.
- pass holds its value until the next run's SETTLE.
- Latency: start sampled at edge E0 with N bytes buffered -> done high in cycle N+3 after E0.
  - Cycle 1: CLR. Cycles 2..N+1: FEED. Cycle N+2: SETTLE. Cycle N+3: DONE.
- While busy or in DONE:
  - wr_en is ignored (not stored, ovf unchanged).
  - full=1; start and clear are ignored.
- full = (count==DEPTH) OR (state!=IDLE).
- Pointers wrap modulo DEPTH; count is AW+1 bits so DEPTH is representable.
- Reset mid-run: returns to IDLE the next cycle and discards the FIFO. chk_reset is high during reset, so the checker also clears. No done pulse.

Test Plan:
- Write "begin end " (10 bytes), start -> chk_in sequence b,e,g,i,n,' ',e,n,d,' ' on consecutive cycles; done in cycle 13 after start; pass=1.
- Write "end begin " (10 bytes), start -> done at cycle 13; pass=0. Then a run of "begin end " -> pass=1 (checker cleared by CLR between runs).
- Start with empty FIFO -> chk_reset high 1 cycle, no FEED cycles, done in cycle 3, pass=1, count stays 0.
- Write 17 bytes in IDLE -> count=16 and full=1 after 16; 17th dropped, ovf=1. start -> ovf clears in CLR; the 16 bytes stream in order.
- wr_en pulses during FEED -> ignored, count=0 after done. clear+wr_en in same IDLE cycle -> count=0.
- Assert reset during FEED of "begin begin " -> next cycle IDLE, count=0, done never pulses, chk_reset=1 while reset is held.
